// File: rtl/clarvi_alu_sequencer_pkg.sv
// Shared types for the two-pass RV64 ALU sequencer and its 32-bit ALU.
package clarvi_alu_sequencer_pkg;

  localparam int XLEN  = 64;
  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SLT,
    OP_SLTU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SL,
    OP_SRL,
    OP_SRA,
    OP_AUIPC
  } op_t;

  // instr_part selects which 32-bit word the ALU works on (0 = lower, 1 = upper).
  typedef struct packed {
    op_t               op;
    logic [ALU_W-1:0]  immediate;
    logic              immediate_used;
    logic              is32_bit_op;
    logic [XLEN-1:0]   pc;
    logic              funct7_bit;
    logic              instr_part;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    DONE
  } seq_state_t;

  function automatic logic is_shift(op_t op);
    return op inside {OP_SL, OP_SRL, OP_SRA};
  endfunction

  // Compares and right shifts need the upper word's outcome before the lower word.
  function automatic logic is_upper_first(instr_t instr);
    return !instr.is32_bit_op && (instr.op inside {OP_SLT, OP_SLTU, OP_SRL, OP_SRA});
  endfunction

endpackage

// File: rtl/clarvi_alu_sequencer_alu.sv
// 32-bit ALU slice. A 64-bit op runs as two passes; the state register carries
// carry, compare flags, shifted-out bits and the 32-bit result sign between them.
// The first pass of any op never reads that state.
module clarvi_ALU
  import clarvi_alu_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  instr_t            instr,
  input  logic [ALU_W-1:0]  rs1,
  input  logic [ALU_W-1:0]  rs2,
  output logic [ALU_W-1:0]  result
);

  logic               carry_q, carry_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               sign_q, sign_d;
  logic [ALU_W-1:0]   spill_q, spill_d;

  logic               upper;
  logic               subtract;
  logic               carry_in;
  logic [ALU_W-1:0]   op_a, op_b, op_b_eff;
  logic [ALU_W:0]     sum;
  logic               lt_unsigned, lt_signed, half_lt;
  logic [5:0]         shamt;
  logic [2*ALU_W-1:0] shl_wide, shr_logic, shr_arith, shr_wide;

  // Per-pass datapath and next value of the inter-pass state.
  always_comb begin
    upper    = instr.instr_part;
    op_a     = (instr.op == OP_AUIPC) ? (upper ? instr.pc[2*ALU_W-1:ALU_W] : instr.pc[ALU_W-1:0])
                                      : rs1;
    op_b     = (instr.immediate_used || instr.op == OP_AUIPC) ? instr.immediate : rs2;
    subtract = (instr.op == OP_ADD) && instr.funct7_bit && !instr.immediate_used;
    op_b_eff = subtract ? ~op_b : op_b;
    carry_in = (upper && !instr.is32_bit_op) ? carry_q : subtract;
    sum      = {1'b0, op_a} + {1'b0, op_b_eff} + {{ALU_W{1'b0}}, carry_in};

    lt_unsigned = op_a < op_b;
    lt_signed   = $signed(op_a) < $signed(op_b);
    half_lt     = (instr.op == OP_SLT && (upper || instr.is32_bit_op)) ? lt_signed : lt_unsigned;

    // Shifts place the word at one end of a 64-bit window so the bits that
    // cross the word boundary land in the other half and become the spill.
    shamt     = instr.is32_bit_op ? {1'b0, op_b[4:0]} : op_b[5:0];
    shl_wide  = {{ALU_W{1'b0}}, op_a} << shamt;
    shr_logic = {op_a, {ALU_W{1'b0}}} >> shamt;
    shr_arith = $signed({op_a, {ALU_W{1'b0}}}) >>> shamt;
    shr_wide  = (instr.op == OP_SRA) ? shr_arith : shr_logic;

    result  = '0;
    spill_d = '0;
    case (instr.op)
      OP_ADD, OP_AUIPC: result = sum[ALU_W-1:0];
      OP_AND:           result = op_a & op_b;
      OP_OR:            result = op_a | op_b;
      OP_XOR:           result = op_a ^ op_b;
      OP_SLT, OP_SLTU: begin
        if (instr.is32_bit_op) begin
          result = {{(ALU_W-1){1'b0}}, half_lt};
        end else if (!upper) begin
          result = {{(ALU_W-1){1'b0}}, eq_q ? lt_unsigned : lt_q};
        end
      end
      OP_SL: begin
        if (upper) begin
          result = (shamt[5] ? '0 : (op_a << shamt[4:0])) | spill_q;
        end else begin
          result  = shl_wide[ALU_W-1:0];
          spill_d = shl_wide[2*ALU_W-1:ALU_W];
        end
      end
      OP_SRL, OP_SRA: begin
        if (upper || instr.is32_bit_op) begin
          result  = shr_wide[2*ALU_W-1:ALU_W];
          spill_d = shr_wide[ALU_W-1:0];
        end else begin
          result = (shamt[5] ? '0 : (op_a >> shamt[4:0])) | spill_q;
        end
      end
      default: result = '0;
    endcase

    if (upper && instr.is32_bit_op) begin
      result = {ALU_W{sign_q}};
    end

    carry_d = sum[ALU_W];
    eq_d    = (op_a == op_b);
    lt_d    = half_lt;
    sign_d  = result[ALU_W-1];
  end

  // Inter-pass state only advances on cycles the sequencer lets the ALU run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      sign_q  <= 1'b0;
      spill_q <= '0;
    end else if (!stall) begin
      carry_q <= carry_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      sign_q  <= sign_d;
      spill_q <= spill_d;
    end
  end

endmodule

// File: rtl/clarvi_alu_sequencer.sv
// Two-pass sequencer: issues a 64-bit op to the 32-bit ALU as two word passes
// and assembles the result behind a valid/ready output.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high when not stalled
// FIRST  | first pass (upper word for compares/right shifts, else lower)
// SECOND | the other word
// DONE   | out_valid high until out_ready
module clarvi_alu_sequencer
  import clarvi_alu_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  instr_t           in_instr,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result
);

  seq_state_t        state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic [ALU_W-1:0]  part0_q, part1_q;

  logic              accept;
  logic              capture;
  logic              alu_stall;
  logic              instr_part;
  instr_t            alu_instr;
  logic [ALU_W-1:0]  alu_rs1, alu_rs2, alu_result;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/ALU control; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    alu_stall  = 1'b1;
    instr_part = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !stall && !reset;
        accept   = in_valid && in_ready && !flush;
        if (accept) state_d = FIRST;
      end
      FIRST: begin
        alu_stall  = stall;
        instr_part = instr_q.instr_part;
        capture    = !stall && !flush;
        if (!stall) state_d = SECOND;
      end
      SECOND: begin
        alu_stall  = stall;
        instr_part = !instr_q.instr_part;
        capture    = !stall && !flush;
        if (!stall) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready && !stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Latched instruction remembers its first-pass word in instr_part.
  always_comb begin
    instr_d            = in_instr;
    instr_d.instr_part = is_upper_first(in_instr);
  end

  // Per-pass operand and immediate rewrite; shifts keep the same amount on both passes.
  always_comb begin
    alu_instr            = instr_q;
    alu_instr.instr_part = instr_part;
    alu_rs1              = instr_part ? rs1_q[XLEN-1:ALU_W] : rs1_q[ALU_W-1:0];
    alu_rs2              = rs2_q[ALU_W-1:0];
    if (instr_part && !is_shift(instr_q.op)) begin
      alu_instr.immediate = {ALU_W{instr_q.immediate[ALU_W-1]}};
      alu_rs2             = rs2_q[XLEN-1:ALU_W];
    end
  end

  // Request latch and result-half capture; flush discards the halves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      part0_q <= '0;
      part1_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr_d;
        rs1_q   <= in_rs1;
        rs2_q   <= in_rs2;
      end
      if (flush) begin
        part0_q <= '0;
        part1_q <= '0;
      end else if (capture) begin
        if (instr_part) part1_q <= alu_result;
        else            part0_q <= alu_result;
      end
    end
  end

  assign out_result = {part1_q, part0_q};

  clarvi_ALU u_alu (
    .clock  (clock),
    .reset  (reset),
    .stall  (alu_stall),
    .instr  (alu_instr),
    .rs1    (alu_rs1),
    .rs2    (alu_rs2),
    .result (alu_result)
  );

endmodule

// File: tb/tb_clarvi_alu_sequencer.sv
// Directed bench for clarvi_alu_sequencer.
module tb_clarvi_alu_sequencer;
  import clarvi_alu_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  instr_t      in_instr;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int checks;
  int errors;

  clarvi_alu_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic instr_t mk(op_t op, logic [31:0] imm, logic imm_used, logic is32, logic f7);
    instr_t i;
    i                = '0;
    i.op             = op;
    i.immediate      = imm;
    i.immediate_used = imm_used;
    i.is32_bit_op    = is32;
    i.funct7_bit     = f7;
    return i;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 time unit after that edge.
  task automatic issue(input instr_t instr, input logic [63:0] a, input logic [63:0] b);
    in_instr = instr;
    in_rs1   = a;
    in_rs2   = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Issue and advance to the first cycle in which out_valid should be high.
  task automatic run_op(input instr_t instr, input logic [63:0] a, input logic [63:0] b);
    issue(instr, a, b);
    tick(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({out_valid, out_result} !== {1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%h exp v=0 r=0", out_valid, out_result);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    checks++;
    if ({dut.alu_stall, dut.instr_part} !== 2'b10) begin
      errors++;
      $display("FAIL reset_alu_ctrl got stall=%b part=%b exp stall=1 part=0", dut.alu_stall, dut.instr_part);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got %b exp 1", in_ready);
    end
    tick(1);
  endtask

  task automatic test_add64;
    issue(mk(OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0), 64'h0000_0000_FFFF_FFFF, 64'h1);
    checks++;
    if ({out_valid, in_ready, dut.instr_part} !== 3'b000) begin
      errors++;
      $display("FAIL add64_first got v=%b rdy=%b part=%b exp 0 0 0", out_valid, in_ready, dut.instr_part);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add64_second_valid got %b exp 0", out_valid);
    end
    tick(1);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h0000_0001_0000_0000}) begin
      errors++;
      $display("FAIL add64_result got v=%b r=%h exp v=1 r=0000000100000000", out_valid, out_result);
    end
    tick(1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL add64_return_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_addw;
    run_op(mk(OP_ADD, 32'h0, 1'b0, 1'b1, 1'b0), 64'h0000_0000_7FFF_FFFF, 64'h1);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'hFFFF_FFFF_8000_0000}) begin
      errors++;
      $display("FAIL addw_result got v=%b r=%h exp v=1 r=ffffffff80000000", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_srai;
    issue(mk(OP_SRA, 32'd4, 1'b1, 1'b0, 1'b0), 64'h8000_0000_0000_0000, 64'h0);
    checks++;
    if (dut.instr_part !== 1'b1) begin
      errors++;
      $display("FAIL srai_upper_first got part=%b exp 1", dut.instr_part);
    end
    tick(2);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'hF800_0000_0000_0000}) begin
      errors++;
      $display("FAIL srai_result got v=%b r=%h exp v=1 r=f800000000000000", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_sltu;
    run_op(mk(OP_SLTU, 32'h0, 1'b0, 1'b0, 1'b0), 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL sltu_result got v=%b r=%h exp v=1 r=0", out_valid, out_result);
    end
    tick(1);
    run_op(mk(OP_SLTU, 32'h0, 1'b0, 1'b0, 1'b0), 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h1}) begin
      errors++;
      $display("FAIL sltu_swapped got v=%b r=%h exp v=1 r=1", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_immediates;
    run_op(mk(OP_ADD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0), 64'h0000_0001_0000_0000, 64'h0);
    checks++;
    if (out_result !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL addi_neg got %h exp 00000000ffffffff", out_result);
    end
    tick(1);
    run_op(mk(OP_AND, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b0), 64'h1234_5678_9ABC_DEF0, 64'h0);
    checks++;
    if (out_result !== 64'h1234_5678_9ABC_DE00) begin
      errors++;
      $display("FAIL andi_sext got %h exp 123456789abcde00", out_result);
    end
    tick(1);
    run_op(mk(OP_SL, 32'd33, 1'b1, 1'b0, 1'b0), 64'h0000_0000_8000_0001, 64'h0);
    checks++;
    if (out_result !== 64'h0000_0002_0000_0000) begin
      errors++;
      $display("FAIL slli_33 got %h exp 0000000200000000", out_result);
    end
    tick(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    run_op(mk(OP_ADD, 32'h0, 1'b0, 1'b0, 1'b1), 64'h0, 64'h1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, out_result} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b rdy=%b r=%h exp v=1 rdy=0 r=ffffffffffffffff",
                 i, out_valid, in_ready, out_result);
      end
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    run_op(mk(OP_SL, 32'h0, 1'b0, 1'b0, 1'b0), 64'h0F00_0000_F000_0001, 64'd4);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'hF000_000F_0000_0010}) begin
      errors++;
      $display("FAIL bp_next_op got v=%b r=%h exp v=1 r=f000000f00000010", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_flush;
    issue(mk(OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0), 64'hFFFF_FFFF, 64'h1);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_second got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    tick(2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_valid got %b exp 0", out_valid);
    end
    in_instr = mk(OP_OR, 32'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick(1);
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_beats_accept got rdy=%b exp 1", in_ready);
    end
    run_op(mk(OP_SRL, 32'h0, 1'b0, 1'b0, 1'b0), 64'hFFFF_FFFF_0000_0000, 64'd36);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h0000_0000_0FFF_FFFF}) begin
      errors++;
      $display("FAIL flush_recover_srl got v=%b r=%h exp v=1 r=000000000fffffff", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_stall;
    issue(mk(OP_SLT, 32'h0, 1'b0, 1'b0, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL stall_first cycle %0d got v=%b rdy=%b exp 0 0", i, out_valid, in_ready);
      end
    end
    stall = 1'b0;
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_early_valid got %b exp 0", out_valid);
    end
    tick(1);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h1}) begin
      errors++;
      $display("FAIL stall_slt_result got v=%b r=%h exp v=1 r=1", out_valid, out_result);
    end
    tick(1);
    issue(mk(OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0), 64'h0000_0001_FFFF_FFFF, 64'h0000_0002_0000_0001);
    tick(1);
    stall = 1'b1;
    tick(2);
    stall = 1'b0;
    tick(1);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h0000_0004_0000_0000}) begin
      errors++;
      $display("FAIL stall_second_carry got v=%b r=%h exp v=1 r=0000000400000000", out_valid, out_result);
    end
    tick(1);
  endtask

  task automatic test_reset_mid;
    issue(mk(OP_SRA, 32'd4, 1'b1, 1'b0, 1'b0), 64'h8000_0000_0000_0000, 64'h0);
    tick(1);
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, out_result} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b rdy=%b r=%h exp 0 0 0", out_valid, in_ready, out_result);
    end
    tick(1);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got %b exp 1", in_ready);
    end
    tick(3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    run_op(mk(OP_XOR, 32'h0, 1'b0, 1'b0, 1'b0), 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_FFFF_FFFF);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'hF0F0_0F0F_EDCB_A987}) begin
      errors++;
      $display("FAIL b2b_xor got v=%b r=%h exp v=1 r=f0f00f0fedcba987", out_valid, out_result);
    end
    in_instr = mk(OP_OR, 32'h0, 1'b0, 1'b0, 1'b0);
    in_rs1   = 64'h8000_0000_0000_0001;
    in_rs2   = 64'h0000_0001_8000_0000;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_in_done got %b exp 0", in_ready);
    end
    tick(1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    tick(1);
    in_valid = 1'b0;
    tick(2);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 64'h8000_0001_8000_0001}) begin
      errors++;
      $display("FAIL b2b_or got v=%b r=%h exp v=1 r=8000000180000001", out_valid, out_result);
    end
    tick(1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    test_reset();
    test_add64();
    test_addw();
    test_srai();
    test_sltu();
    test_immediates();
    test_backpressure();
    test_flush();
    test_stall();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clarvi_alu_sequencer.md
# clarvi_alu_sequencer

Two-pass sequencer wrapping the 32-bit `clarvi_ALU` so the execute stage can issue full RV64 integer ops (and `*W` 32-bit ops) as one transaction. It accepts one instruction plus 64-bit operands over a valid/ready handshake and picks the pass order: lower word first or upper word first. It rewrites operands and the immediate per pass, gates the ALU's inter-pass state register and assembles a 64-bit result behind an output valid/ready handshake. It sits between issue/operand-read and writeback; the execute stage sees only this block.

## Interface
- No parameters; widths fixed by `instr_t` (XLEN 64, ALU datapath 32).
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_instr` in `instr_t`: decoded instruction (`op`, `immediate`, `immediate_used`, `is32_bit_op`, `pc`, `funct7_bit`).
- `in_rs1`, `in_rs2` in 64 each: operand values.
- `stall` in 1: pipeline stall; freezes the FSM and the ALU state register.
- `flush` in 1: discard in-flight op.
- `out_valid` out 1: `out_result` holds a completed op.
- `out_ready` in 1: consumer accepts result.
- `out_result` out 64: assembled result.

## Operation
- States: IDLE, FIRST, SECOND, DONE.
- IDLE, on `in_valid && in_ready && !stall`: latch instr/operands; compute `upper_first = !is32_bit_op && op ∈ {SLT, SLTU, SRL, SRA}`; go FIRST.
- FIRST: drive the ALU with `instr_part = upper_first ? 1 : 0`; capture that result half; go SECOND.
- SECOND: drive the other part; capture the other half; go DONE.
- DONE: `out_valid=1`; on `out_ready` go IDLE.
- Per-pass operands for part 0: `rs1[31:0]` and `rs2[31:0]`, immediate unchanged.
- Per-pass operands for part 1: `rs1[63:32]` and `rs2[63:32]`, immediate replaced by `{32{immediate[31]}}`.
- Exception, shifts (SL/SRL/SRA): both passes use `rs2[31:0]` and the unmodified immediate, so the shift amount is identical.
- Result assembly: `out_result = {part1_half, part0_half}` regardless of order. For `is32_bit_op`, part 1 yields the sign extension produced by the ALU.
- ALU stall gating: `alu_stall = !(state ∈ {FIRST, SECOND}) || stall`. The carry/compare/underflow state therefore updates exactly once per pass and is never corrupted between ops.
- `stall` in FIRST/SECOND/DONE: hold state, captured halves and outputs.
- `flush`: from any state, next state is IDLE. Captured halves are discarded and `out_valid` drops next cycle.
  - `flush` wins over `stall` and over a simultaneous accept.
  - With `flush` and `out_ready` both high in DONE, go IDLE; consumer treats the result as dropped.

## Timing
- Accept on edge N; FIRST during cycle N+1; SECOND during N+2; `out_valid` high from N+3.
- Throughput: one op per 4 cycles with `out_ready` tied high, plus stall cycles.
- `in_ready` is combinational: `state==IDLE && !stall && !reset`.
- `out_result` is registered and stable while `out_valid && !out_ready`.
- Reset values (async, during and after `reset`):
  - state IDLE, `out_valid=0`, `out_result=0`, captured halves 0.
  - Internal `alu_stall=1`, `instr_part=0`.
- `in_ready` is 1 the first cycle after `reset` deasserts.
- Reset mid-operation: op lost, no `out_valid` pulse.

## Structure
- Shared `riscv.svh` package holds:
  - `seq_state_t` enum (IDLE/FIRST/SECOND/DONE).
  - `function is_upper_first(instr_t)`.
  - `function is_shift(op_t)`.
- The existing `instr_t` and op enum are reused unchanged.
- One sub-module: an instance of `clarvi_ALU`. It receives the per-pass `instr_t` (with `instr_part` and rewritten `immediate`), the per-pass operands and `stall = alu_stall`. Its `reset` is tied to `reset`.
- The FSM, operand muxing and result registers live in `clarvi_alu_sequencer`.

## Test plan
- ADD 64-bit, `rs1=0x00000000_FFFFFFFF`, `rs2=1` -> `out_result=0x00000001_00000000` at N+3; carry crosses halves.
- ADDW, `rs1=0x7FFFFFFF`, `rs2=1` -> `0xFFFFFFFF_80000000`.
- SRAI, `rs1=0x80000000_00000000`, imm 4 -> `0xF8000000_00000000`; upper pass issued first.
- SLTU, `rs1=0x00000001_00000000`, `rs2=0x00000000_FFFFFFFF` -> 0. Swapped operands -> 1.
- Backpressure: `out_ready` low 5 cycles after `out_valid` -> result held stable, `in_ready=0`; `out_ready` high -> IDLE next cycle, next op accepted.
- Disruptions:
  - `flush` during SECOND -> no `out_valid`, `in_ready=1` next cycle.
  - `stall` for 3 cycles in FIRST -> result identical, delivered 3 cycles later.
  - `reset` asserted in SECOND -> all outputs 0 immediately.
